// File: rtl/nn_bus_pkg.sv
// Shared types and constants for the NN bus arbiter.
// Holds the bus widths, direction codes and arbiter state encoding.
package nn_bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic {
        IDLE,
        ISSUE
    } nn_arb_state_t;

endpackage

// File: rtl/nn_rd_tag_fifo.sv
// Tag FIFO remembering which requester issued each outstanding read.
// Push and pop may happen together, even when full.
module nn_rd_tag_fifo
    import nn_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             pop_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW:0]      count_o
);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign tag_o   = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Tag storage; contents are meaningless while not counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= tag_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/nn_bus_arbiter.sv
// Round-robin arbiter sharing one NN block bus among requesters.
// Read responses are routed back in issue order via a tag FIFO.
module nn_bus_arbiter
    import nn_bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ADDR_W   = nn_bus_pkg::ADDR_W,
    parameter int DATA_W   = nn_bus_pkg::DATA_W,
    parameter int RD_DEPTH = 4,
    localparam int TAG_W   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(RD_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        rw_i,
    input  logic [NREQ*ADDR_W-1:0] addr_i,
    input  logic [NREQ*DATA_W-1:0] wdata_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [NREQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   RW,
    output logic                   sel,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_W-1:0]      din,
    input  logic [DATA_W-1:0]      dout,
    input  logic                   bus_stop,
    input  logic                   pushout,
    output logic [CW-1:0]          rd_outstanding_o,
    output logic                   err_o
);

    nn_arb_state_t     state_q, state_d;
    logic [TAG_W-1:0]  rr_q, rr_d;
    logic [TAG_W-1:0]  owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              rd_full;
    logic              rd_empty;
    logic [TAG_W-1:0]  rd_tag;
    logic              push;
    logic              pop;
    logic [NREQ-1:0]   elig;
    logic [TAG_W:0]    pick;
    logic [TAG_W-1:0]  widx;

    // First set bit of el at or after ptr, wrapping; MSB flags a hit.
    function automatic logic [TAG_W:0] rr_pick(
        input logic [NREQ-1:0]  el,
        input logic [TAG_W-1:0] ptr
    );
        logic [TAG_W:0] r;
        int j;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NREQ;
            if (el[j]) begin
                r = {1'b1, TAG_W'(j)};
            end
        end
        return r;
    endfunction

    assign elig = req_i & ~(~rw_i & {NREQ{rd_full}});
    assign pick = rr_pick(elig, rr_q);
    assign widx = pick[TAG_W-1:0];
    assign pop  = pushout & ~rd_empty;

    // Arbitration and bus-ownership FSM.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        din_d   = din_q;
        push    = 1'b0;
        ack_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick[TAG_W]) begin
                    state_d = ISSUE;
                    owner_d = widx;
                    rw_d    = rw_i[widx];
                    addr_d  = addr_i[int'(widx)*ADDR_W +: ADDR_W];
                    din_d   = wdata_i[int'(widx)*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                if (!bus_stop) begin
                    ack_o   = NREQ'(1) << owner_q;
                    state_d = IDLE;
                    push    = (rw_q == RW_READ);
                    if (owner_q == TAG_W'(NREQ - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = owner_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response routing and sticky error flag.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (pop) begin
            rvalid_d = NREQ'(1) << rd_tag;
            rdata_d  = dout;
        end else if (pushout) begin
            err_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign sel      = (state_q == ISSUE);
    assign RW       = rw_q;
    assign addr     = addr_q;
    assign din      = din_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    nn_rd_tag_fifo #(
        .DEPTH (RD_DEPTH),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .tag_i   (owner_q),
        .pop_i   (pop),
        .tag_o   (rd_tag),
        .full_o  (rd_full),
        .empty_o (rd_empty),
        .count_o (rd_outstanding_o)
    );

endmodule

// File: tb/tb_nn_bus_arbiter.sv
// Directed bench for nn_bus_arbiter: grant order, stalls,
// read routing, full tag FIFO, error flag and async reset.
module tb_nn_bus_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 20;
    localparam int DW   = 32;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] rw_i;
    logic [NREQ*AW-1:0] addr_i;
    logic [NREQ*DW-1:0] wdata_i;
    logic [NREQ-1:0] ack_o;
    logic [NREQ-1:0] rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            RW;
    logic            sel;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   din;
    logic [DW-1:0]   dout;
    logic            bus_stop;
    logic            pushout;
    logic [CW-1:0]   rd_outstanding_o;
    logic            err_o;

    int n_chk  = 0;
    int n_fail = 0;

    nn_bus_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req_i            (req_i),
        .rw_i             (rw_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .ack_o            (ack_o),
        .rvalid_o         (rvalid_o),
        .rdata_o          (rdata_o),
        .RW               (RW),
        .sel              (sel),
        .addr             (addr),
        .din              (din),
        .dout             (dout),
        .bus_stop         (bus_stop),
        .pushout          (pushout),
        .rd_outstanding_o (rd_outstanding_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_i[r] = 1'b1;
        rw_i[r]  = w;
        addr_i[r*AW +: AW] = a;
        wdata_i[r*DW +: DW] = d;
    endtask

    task automatic xact(input int r, input logic w,
                        input logic [AW-1:0] a);
        logic [NREQ-1:0] e;
        e = '0;
        e[r] = 1'b1;
        set_req(r, w, a, 32'h0);
        step();
        chk("xact_ack", 64'(ack_o), 64'(e));
        req_i[r] = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    logic [NREQ-1:0] rr_exp [5];

    initial begin
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        req_i    = '0;
        rw_i     = '0;
        addr_i   = '0;
        wdata_i  = '0;
        dout     = '0;
        bus_stop = 1'b0;
        pushout  = 1'b0;
        reset    = 1'b0;
        #2;
        chk("rst_sel", 64'(sel), 64'h0);
        chk("rst_ack", 64'(ack_o), 64'h0);
        chk("rst_rdata", 64'(rdata_o), 64'h0);
        chk("rst_out", 64'(rd_outstanding_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        chk("rst_addr", 64'(addr), 64'h0);
        step();
        reset = 1'b1;
        step();

        // single write
        set_req(1, 1'b1, 20'h00040, 32'hDEADBEEF);
        step();
        chk("wr_sel", 64'(sel), 64'h1);
        chk("wr_rw", 64'(RW), 64'h1);
        chk("wr_addr", 64'(addr), 64'h00040);
        chk("wr_din", 64'(din), 64'hDEADBEEF);
        chk("wr_ack", 64'(ack_o), 64'h2);
        req_i = '0;
        step();
        chk("wr_sel_off", 64'(sel), 64'h0);
        chk("wr_ack_off", 64'(ack_o), 64'h0);

        // round robin from a fresh pointer
        do_reset();
        rw_i = 4'b1111;
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_ack", 64'(ack_o), 64'(rr_exp[k]));
            step();
            chk("rr_bubble", 64'(sel), 64'h0);
        end
        req_i = '0;

        // back-pressure
        bus_stop = 1'b1;
        set_req(3, 1'b1, 20'h12345, 32'hCAFEF00D);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_sel", 64'(sel), 64'h1);
            chk("bp_addr", 64'(addr), 64'h12345);
            chk("bp_din", 64'(din), 64'hCAFEF00D);
            chk("bp_ack", 64'(ack_o), 64'h0);
            step();
        end
        bus_stop = 1'b0;
        #1;
        chk("bp_ack_go", 64'(ack_o), 64'h8);
        req_i = '0;
        step();
        chk("bp_sel_off", 64'(sel), 64'h0);

        // read routing
        xact(2, 1'b0, 20'h00100);
        chk("rd_out1", 64'(rd_outstanding_o), 64'h1);
        set_req(0, 1'b0, 20'h00200, 32'h0);
        step();
        chk("rd_addr0", 64'(addr), 64'h00200);
        chk("rd_ack0", 64'(ack_o), 64'h1);
        req_i = '0;
        step();
        chk("rd_out2", 64'(rd_outstanding_o), 64'h2);
        pushout = 1'b1;
        dout = 32'hAAAA;
        step();
        dout = 32'hBBBB;
        chk("rd_rv2", 64'(rvalid_o), 64'h4);
        chk("rd_data2", 64'(rdata_o), 64'hAAAA);
        step();
        pushout = 1'b0;
        chk("rd_rv0", 64'(rvalid_o), 64'h1);
        chk("rd_data0", 64'(rdata_o), 64'hBBBB);
        step();
        chk("rd_rv_off", 64'(rvalid_o), 64'h0);
        chk("rd_hold", 64'(rdata_o), 64'hBBBB);
        chk("rd_out0", 64'(rd_outstanding_o), 64'h0);

        // full tag FIFO
        for (int k = 0; k < 4; k++) begin
            xact(0, 1'b0, 20'h00300);
        end
        chk("full_out4", 64'(rd_outstanding_o), 64'h4);
        set_req(1, 1'b0, 20'h00400, 32'h0);
        set_req(3, 1'b1, 20'h00500, 32'h55);
        step();
        chk("full_wr_ack", 64'(ack_o), 64'h8);
        req_i[3] = 1'b0;
        step();
        chk("full_idle", 64'(sel), 64'h0);
        pushout = 1'b1;
        dout = 32'h1111;
        step();
        pushout = 1'b0;
        chk("full_out3", 64'(rd_outstanding_o), 64'h3);
        chk("full_held", 64'(sel), 64'h0);
        chk("full_rv", 64'(rvalid_o), 64'h1);
        step();
        chk("full_rd_ack", 64'(ack_o), 64'h2);
        req_i = '0;
        step();
        chk("full_out4b", 64'(rd_outstanding_o), 64'h4);
        pushout = 1'b1;
        repeat (4) step();
        pushout = 1'b0;
        chk("drain_out0", 64'(rd_outstanding_o), 64'h0);
        step();

        // stray response
        pushout = 1'b1;
        step();
        pushout = 1'b0;
        chk("err_set", 64'(err_o), 64'h1);
        chk("err_no_rv", 64'(rvalid_o), 64'h0);

        // async reset mid-issue, then a stale response
        bus_stop = 1'b1;
        set_req(0, 1'b0, 20'h00600, 32'h0);
        step();
        chk("mid_sel", 64'(sel), 64'h1);
        reset = 1'b0;
        #1;
        chk("async_sel", 64'(sel), 64'h0);
        req_i = '0;
        bus_stop = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("post_err", 64'(err_o), 64'h0);
        chk("post_out", 64'(rd_outstanding_o), 64'h0);
        pushout = 1'b1;
        step();
        pushout = 1'b0;
        chk("stale_err", 64'(err_o), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_bus_arbiter.md
Name: nn_bus_arbiter

Overview:
Shares one neural-network block's register/data bus between NREQ requesters (host loader, weight DMA, result reader, debug). It arbitrates round-robin, drives the block's driver-side signals (RW, sel, addr, din) and honours bus_stop back-pressure. It routes read data returned on pushout/dout back to the requester that issued the read, in issue order.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_W, 20, NN address width
DATA_W, 32, NN data width
RD_DEPTH, 4, max outstanding reads (power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_i  in  NREQ  per-requester request; held with fields stable until ack
rw_i  in  NREQ  per-requester direction; 1=write, 0=read
addr_i  in  NREQ*ADDR_W  per-requester address
wdata_i  in  NREQ*DATA_W  per-requester write data
ack_o  out  NREQ  one-hot; request accepted by NN this cycle
rvalid_o  out  NREQ  one-hot; read data valid for that requester
rdata_o  out  DATA_W  read data, shared by all requesters
RW  out  1  to NN; 1=write
sel  out  1  to NN; transaction valid
addr  out  ADDR_W  to NN
din  out  DATA_W  to NN write data
dout  in  DATA_W  from NN read data
bus_stop  in  1  from NN; 1=cannot accept this cycle
pushout  in  1  from NN; dout valid
rd_outstanding_o  out  $clog2(RD_DEPTH)+1  reads issued and not yet returned
err_o  out  1  sticky: pushout arrived with no outstanding read

Behaviour:
- Reset (reset=0, async): sel=0, RW=0, addr=0, din=0, ack_o=0, rvalid_o=0, rdata_o=0, err_o=0, rd_outstanding_o=0. State=IDLE, RR pointer=0, tag FIFO empty.
- FSM states: IDLE, ISSUE.
- IDLE: eligible = req_i & ~(~rw_i & {NREQ{rd_full}}); reads are masked while the tag FIFO is full.
  - Winner = first eligible index at or after the RR pointer, with wrap-around.
  - If any eligible: register RW/addr/din from the winner, set sel=1, record owner, go to ISSUE.
  - Otherwise remain in IDLE.
- ISSUE: sel stays 1 and the bus fields stay constant.
  - ack_o[owner] = !bus_stop (combinational, from state/owner registers and bus_stop).
  - On an edge with bus_stop=0 (accept):
    - sel<=0; RR pointer <= owner+1 (mod NREQ); next state IDLE.
    - If the transaction is a read, push owner into the tag FIFO.
  - On an edge with bus_stop=1: hold everything. A stall of any length is legal.
- Throughput: at most one transaction per 2 cycles (mandatory IDLE bubble). Requester latency from req to sel is 1 cycle.
- Requesters must not drop req_i or change their fields before ack. The arbiter does not check this.
- Response path:
  - On pushout=1 with the FIFO non-empty: pop the tag. Next cycle, rvalid_o[tag]=1 for one cycle and rdata_o=dout as sampled (1-cycle registered latency).
  - rdata_o holds its value until the next response.
- pushout with the FIFO empty: data is dropped, err_o<=1 (cleared only by reset).
- Push and pop in the same cycle: both take effect and rd_outstanding_o is unchanged. This is legal at any occupancy, including full (the pop frees the slot).
- rd_outstanding_o = FIFO occupancy, registered.
- Writes get no response. ack completes a write.
- Reset mid-transaction: the bus is released immediately (sel=0) and outstanding tags are discarded. Any later pushout for a pre-reset read sets err_o.

Decomposition:
- Package nn_bus_pkg holds:
  - ADDR_W=20 and DATA_W=32 localparams
  - RW_WRITE=1'b1 and RW_READ=1'b0 constants
  - typedef enum logic {IDLE, ISSUE} nn_arb_state_t
- Sub-module nn_rd_tag_fifo:
  - parameterised DEPTH and tag width $clog2(NREQ)
  - ports push/pop/full/empty/count
  - async active-low reset
  - simultaneous push/pop allowed
- The round-robin select stays inline as a function.

Test Plan:
- Single write: req_i=4'b0010, rw=1, addr=20'h00040, wdata=32'hDEADBEEF, bus_stop=0 → next cycle sel=1, RW=1, addr=20'h00040, din=32'hDEADBEEF, ack_o=4'b0010 that cycle; sel=0 the following cycle.
- Round-robin fairness: all four requesters hold req continuously → grant order 0,1,2,3,0, one grant every 2 cycles; no requester starves.
- Back-pressure: bus_stop=1 for 5 cycles during ISSUE → sel, addr and din stable, ack_o=0 throughout; ack occurs on the first cycle with bus_stop=0.
- Read routing: requester 2 reads 20'h00100, then requester 0 reads 20'h00200; NN returns pushout with 32'hAAAA then 32'hBBBB → rvalid_o=4'b0100 with rdata 32'hAAAA, then rvalid_o=4'b0001 with rdata 32'hBBBB, each 1 cycle after its pushout.
- Full FIFO: 4 reads outstanding, requester 1 read and requester 3 write both pending → write granted, read held; after one pushout the read is granted; rd_outstanding_o goes 4→3→4.
- Error and reset: pushout with no reads outstanding → err_o=1, no rvalid. Assert reset=0 mid-ISSUE → sel=0 asynchronously and err_o=0 after reset.
